// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the 4-bit ALU command driver: opcode enum,
//            datapath width and the packed response record held in the
//            response FIFO.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_W = 4;

   typedef enum logic [2:0] {
      OP_RST0 = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_NOTA = 3'b101,
      OP_NOTB = 3'b110,
      OP_RST1 = 3'b111
   } alu_op_t;

   typedef struct packed {
      logic [ALU_W-1:0] result;
      logic             overflow;
   } alu_rsp_t;

endpackage
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_rsp_fifo
// Purpose  : Synchronous FIFO of ALU responses (result + overflow flag).
//            Flush clears the pointers and occupancy and discards any push
//            or pop requested in the same cycle.
// Ports    : clk, rst_n (async active-low), flush, push/push_data,
//            pop/pop_data (head entry, valid when count != 0), count.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rsp_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  alu_rsp_t                 push_data,
   input  logic                     pop,
   output alu_rsp_t                 pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   alu_rsp_t             mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q,  count_d;
   logic                 push_en;
   logic                 pop_en;

   assign push_en = push && !flush;
   assign pop_en  = pop  && !flush;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count is non-zero.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

`ifndef SYNTHESIS
   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!rst_n) !(push_en && count_q == CNT_W'(DEPTH)));
`endif

endmodule
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Purpose  : Initiator front end for the 4-bit combinational ALU. Commands
//            accepted on a valid/ready stream are registered onto the ALU
//            inputs for one cycle; the ALU result and overflow flag are then
//            captured into a response FIFO drained by a valid/ready stream.
// Ports    : clk, rst_n (async active-low), flush (sync clear)
//            cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op  - command stream
//            alu_a/alu_b/alu_op, alu_result/alu_overflow - ALU hookup
//            rsp_valid/rsp_ready/rsp_result/rsp_overflow - response stream
//            fifo_count - response FIFO occupancy
//            stat_ops/stat_ovf - push / overflow counters (only when
//            ALU_DRIVER_STATS_EN is defined)
// Config   : `define ALU_DRIVER_STATS_EN to add the saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int DATA_W = 4,   // must equal ALU_W
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [DATA_W-1:0]      cmd_a,
   input  logic [DATA_W-1:0]      cmd_b,
   input  logic [2:0]             cmd_op,
   output logic [DATA_W-1:0]      alu_a,
   output logic [DATA_W-1:0]      alu_b,
   output logic [2:0]             alu_op,
   input  logic [DATA_W-1:0]      alu_result,
   input  logic                   alu_overflow,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_result,
   output logic                   rsp_overflow,
   output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_DRIVER_STATS_EN
   ,
   output logic [15:0]            stat_ops,
   output logic [7:0]             stat_ovf
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [2:0]          alu_op_q, alu_op_d;
   logic                accept;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    occupancy;
   alu_rsp_t            push_data;
   alu_rsp_t            rsp_head;

   // The in-flight command already owns a FIFO slot, so it counts toward
   // occupancy; this is what guarantees a push never finds the FIFO full.
   assign occupancy = fifo_count + CNT_W'(state_q == S_ISSUE);
   assign cmd_ready = rst_n && !flush && (occupancy < CNT_W'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;

   // Every ISSUE cycle ends with a capture of the ALU output.
   assign push      = (state_q == S_ISSUE);
   assign pop       = rsp_valid && rsp_ready;
   assign push_data = '{result: alu_result, overflow: alu_overflow};

   always_comb begin
      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (accept) begin
         state_d  = S_ISSUE;
         alu_a_d  = cmd_a;
         alu_b_d  = cmd_b;
         alu_op_d = cmd_op;
      end else begin
         state_d = S_IDLE;
      end
   end

`ifdef ALU_DRIVER_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d;
   logic [7:0]  stat_ovf_q, stat_ovf_d;

   always_comb begin
      stat_ops_d = stat_ops_q;
      stat_ovf_d = stat_ovf_q;
      if (flush) begin
         stat_ops_d = '0;
         stat_ovf_d = '0;
      end else if (push) begin
         if (stat_ops_q != '1)                  stat_ops_d = stat_ops_q + 16'd1;
         if (alu_overflow && stat_ovf_q != '1)  stat_ovf_d = stat_ovf_q + 8'd1;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_ovf = stat_ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= OP_RST0;
`ifdef ALU_DRIVER_STATS_EN
         stat_ops_q <= '0;
         stat_ovf_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
`ifdef ALU_DRIVER_STATS_EN
         stat_ops_q <= stat_ops_d;
         stat_ovf_q <= stat_ovf_d;
`endif
      end
   end

   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = alu_op_q;

   alu_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (rsp_head),
      .count     (fifo_count)
   );

   assign rsp_valid    = (fifo_count != '0);
   assign rsp_result   = rsp_head.result;
   assign rsp_overflow = rsp_head.overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Purpose  : Self-checking bench for alu_cmd_driver. A behavioural ALU
//            closes the loop; a cycle monitor keeps a reference occupancy
//            model and a scoreboard of expected responses, while directed
//            sequences check latency, backpressure, wrap, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
   import alu_pkg::*;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               flush     = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               rsp_ready = 1'b0;
   logic [DATA_W-1:0]  cmd_a     = '0;
   logic [DATA_W-1:0]  cmd_b     = '0;
   logic [2:0]         cmd_op    = '0;
   logic               cmd_ready;
   logic [DATA_W-1:0]  alu_a, alu_b, alu_result, rsp_result;
   logic [2:0]         alu_op;
   logic               alu_overflow, rsp_valid, rsp_overflow;
   logic [CNT_W-1:0]   fifo_count;
`ifdef ALU_DRIVER_STATS_EN
   logic [15:0]        stat_ops;
   logic [7:0]         stat_ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_cmd_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_op       (cmd_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_overflow (rsp_overflow),
      .fifo_count   (fifo_count)
`ifdef ALU_DRIVER_STATS_EN
      ,
      .stat_ops     (stat_ops),
      .stat_ovf     (stat_ovf)
`endif
   );

   // Reference ALU: returns {overflow, result}; overflow is signed overflow
   // for ADD/SUB and 0 for every other op.
   function automatic logic [DATA_W:0] alu_model(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [2:0] op);
      logic [DATA_W-1:0] r;
      logic              v;
      r = '0;
      v = 1'b0;
      case (alu_op_t'(op))
         OP_ADD:  begin
            r = a + b;
            v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         end
         OP_SUB:  begin
            r = a - b;
            v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOTA: r = ~a;
         OP_NOTB: r = ~b;
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   assign {alu_overflow, alu_result} = alu_model(alu_a, alu_b, alu_op);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it until accepted (bounded).
   task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [2:0] op);
      logic ok;
      int   n;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      n         = 0;
      do begin
         ok = cmd_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      check("send_accepted", ok, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check("rsp_wait", rsp_valid, 1);
   endtask

   // ---------------------------------------------------------------------
   // Cycle monitor: reference occupancy model plus response scoreboard.
   // Evaluated on the falling edge, i.e. with the values the next rising
   // edge will see.
   // ---------------------------------------------------------------------
   logic [DATA_W:0] sb[$];
   int              m_cnt   = 0;
   logic            m_issue = 1'b0;

   always @(negedge clk) begin
      logic            m_ready;
      logic            m_pop;
      logic [DATA_W:0] exp_rsp;
      if (!rst_n) begin
         m_cnt   = 0;
         m_issue = 1'b0;
         sb.delete();
      end else begin
         m_ready = !flush && ((m_cnt + int'(m_issue)) < DEPTH);
         check("mon_cmd_ready", cmd_ready, m_ready);
         check("mon_fifo_count", fifo_count, m_cnt);
         check("mon_rsp_valid", rsp_valid, m_cnt != 0);
         if (flush) begin
            m_cnt   = 0;
            m_issue = 1'b0;
            sb.delete();
         end else begin
            m_pop = (m_cnt != 0) && rsp_ready;
            if (m_pop) begin
               if (sb.size() == 0) begin
                  check("sb_nonempty", sb.size(), 1);
               end else begin
                  exp_rsp = sb.pop_front();
                  check("rsp_data", {rsp_overflow, rsp_result}, exp_rsp);
               end
            end
            m_cnt = m_cnt + int'(m_issue) - int'(m_pop);
            if (cmd_valid && cmd_ready) sb.push_back(alu_model(cmd_a, cmd_b, cmd_op));
            m_issue = cmd_valid && cmd_ready;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int accepted;
      logic rdy;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
`ifdef ALU_DRIVER_STATS_EN
      check("rst_stat_ops", stat_ops, 0);
      check("rst_stat_ovf", stat_ovf, 0);
`endif
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", cmd_ready, 1);
      tick();

      // Single ADD: 7+1 = 8 with signed overflow
      send(4'd7, 4'd1, OP_ADD);
      check("issue_alu_a", alu_a, 7);
      check("issue_alu_b", alu_b, 1);
      check("issue_alu_op", alu_op, 1);
      check("add_not_yet_valid", rsp_valid, 0);
      tick();
      check("add_rsp_valid", rsp_valid, 1);
      check("add_result", rsp_result, 4'b1000);
      check("add_ovf", rsp_overflow, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("add_drained", rsp_valid, 0);

      // SUB then AND back-to-back with the consumer always ready
      rsp_ready = 1'b1;
      send(4'd3, 4'd5, OP_SUB);
      send(4'b1100, 4'b1010, OP_AND);
      check("sub_result", rsp_result, 4'b1110);
      check("sub_ovf", rsp_overflow, 0);
      tick();
      check("and_valid", rsp_valid, 1);
      check("and_result", rsp_result, 4'b1000);
      check("and_ovf", rsp_overflow, 0);
      tick();
      check("b2b_drained", rsp_valid, 0);
      rsp_ready = 1'b0;

      // Backpressure: 6 commands offered over 12 cycles, only 4 fit
      accepted = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         cmd_valid = (accepted < 6);
         cmd_a     = 4'(accepted + 1);
         cmd_b     = 4'd8;
         cmd_op    = OP_OR;
         rdy       = cmd_ready;
         tick();
         if (rdy && cmd_valid) accepted++;
      end
      cmd_valid = 1'b0;
      check("bp_accepted", accepted, 4);
      check("bp_ready_low", cmd_ready, 0);
      check("bp_count_full", fifo_count, 4);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_ready_again", cmd_ready, 1);
      check("bp_count_3", fifo_count, 3);

      // Streaming NOTA through a nearly full FIFO: push and pop overlap,
      // pointers wrap, scoreboard checks ordering (results 15..6).
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(4'(i), 4'd0, OP_NOTA);
      for (int n = 0; n < 20 && fifo_count != 0; n++) tick();
      check("wrap_drained", fifo_count, 0);
      check("wrap_sb_empty", sb.size(), 0);
      rsp_ready = 1'b0;

      // Flush with three queued and one in flight
      send(4'd1, 4'd1, OP_AND);
      send(4'd2, 4'd1, OP_OR);
      send(4'd3, 4'd0, OP_NOTB);
      send(4'd4, 4'd4, OP_SUB);
      check("fl_pre_count", fifo_count, 3);
      flush = 1'b1;
      #1;
      check("fl_ready_low", cmd_ready, 0);
      tick();
      flush = 1'b0;
      check("fl_count", fifo_count, 0);
      check("fl_rsp_valid", rsp_valid, 0);
      tick();
      check("fl_still_empty", rsp_valid, 0);
      send(4'd2, 4'd1, OP_OR);
      rsp_ready = 1'b1;
      wait_rsp();
      check("fl_first_rsp", rsp_result, 4'd3);
      tick();
      rsp_ready = 1'b0;

      // Asynchronous reset during ISSUE
      send(4'd5, 4'd5, OP_ADD);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_alu_a", alu_a, 0);
      check("ar_alu_b", alu_b, 0);
      check("ar_alu_op", alu_op, 0);
      check("ar_cmd_ready", cmd_ready, 0);
      check("ar_rsp_valid", rsp_valid, 0);
      check("ar_fifo_count", fifo_count, 0);
`ifdef ALU_DRIVER_STATS_EN
      check("ar_stat_ops", stat_ops, 0);
      check("ar_stat_ovf", stat_ovf, 0);
`endif
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) tick();
      check("ar_no_stale_rsp", rsp_valid, 0);
      check("ar_count_after", fifo_count, 0);
      check("ar_ready_after", cmd_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
